cmp_hyst_monitor: RTL and testbench

CMP_HYST_MONITOR -- requirements
Module: cmp_hyst_monitor

---
 rtl/cmp_hyst_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_cmp_hyst_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cmp_hyst_monitor.sv
// cmp_hyst_monitor
//   Filters a stream of comparator results (A>B, A<B, A==B flags) with
//   hysteresis. The filtered relation changes only after HOLD consecutive
//   accepted samples agree on a class that differs from the current one.
//   Each change raises a valid/ready event. The block also keeps saturating
//   per-class sample counters.
//
// Configuration macro: CMP_MON_ERR_EN
//   defined   : illegal flag patterns are accepted and then discarded, and
//               set a sticky err flag.
//   undefined : illegal flag patterns count as EQ, and err stays 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   clear      in   synchronous clear of the counters and run tracking
//   in_valid   in   a comparator sample is present
//   in_ready   out  the block accepts the sample this cycle
//   a_greater  in   comparator flag A>B
//   b_greater  in   comparator flag A<B
//   ab_equal   in   comparator flag A==B
//   cur_state  out  filtered relation: 00 EQ, 01 AGT, 10 BGT
//   evt_valid  out  a state-change event is pending
//   evt_ready  in   the consumer takes the event
//   evt_state  out  new state carried by the pending event
//   gt_cnt     out  accepted AGT samples (saturating)
//   lt_cnt     out  accepted BGT samples (saturating)
//   eq_cnt     out  accepted EQ samples (saturating)
//   err        out  sticky illegal-flag indicator
module cmp_hyst_monitor #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 8,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_greater,
  input  logic             b_greater,
  input  logic             ab_equal,
  output logic [1:0]       cur_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_state,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_EQ  = 2'b00,
    ST_AGT = 2'b01,
    ST_BGT = 2'b10
  } state_t;

`ifdef CMP_MON_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [3:0] HOLD_W = 4'(HOLD);

  // Reject parameter values that the logic cannot honour.
  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("cmp_hyst_monitor: HOLD must be in 1..15");
  end
  if (SIZE < 1) begin : g_bad_size
    $error("cmp_hyst_monitor: SIZE must be positive");
  end

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t           state_r, cand_r, evt_state_r;
  logic [3:0]       run_r;
  logic             evt_valid_r, err_r;
  logic [CNT_W-1:0] gt_r, lt_r, eq_r;

  state_t           state_nxt_s, cand_nxt_s, evt_state_nxt_s, cand_new_s, cls_s;
  logic [3:0]       run_nxt_s, run_inc_s;
  logic             evt_valid_nxt_s, err_nxt_s;
  logic [CNT_W-1:0] gt_nxt_s, lt_nxt_s, eq_nxt_s;
  logic             illegal_s, discard_s, in_ready_s, accept_s;

  assign in_ready_s = !clear && (!evt_valid_r || evt_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign discard_s  = ERR_EN && illegal_s;

  // Decode the one-hot comparator flags into a sample class.
  always_comb begin
    cls_s     = ST_EQ;
    illegal_s = 1'b0;
    case ({a_greater, b_greater, ab_equal})
      3'b100:  cls_s = ST_AGT;
      3'b010:  cls_s = ST_BGT;
      3'b001:  cls_s = ST_EQ;
      default: begin
        cls_s     = ST_EQ;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Next-state logic: counters, run/candidate tracking, hysteresis and event.
  always_comb begin
    state_nxt_s     = state_r;
    cand_nxt_s      = cand_r;
    cand_new_s      = cand_r;
    run_nxt_s       = run_r;
    run_inc_s       = 4'd0;
    evt_valid_nxt_s = evt_valid_r && !evt_ready;
    evt_state_nxt_s = evt_state_r;
    gt_nxt_s        = gt_r;
    lt_nxt_s        = lt_r;
    eq_nxt_s        = eq_r;
    err_nxt_s       = err_r;
    if (clear) begin
      gt_nxt_s   = {CNT_W{1'b0}};
      lt_nxt_s   = {CNT_W{1'b0}};
      eq_nxt_s   = {CNT_W{1'b0}};
      run_nxt_s  = 4'd0;
      cand_nxt_s = ST_EQ;
    end else if (accept_s && discard_s) begin
      err_nxt_s = 1'b1;
    end else if (accept_s) begin
      case (cls_s)
        ST_AGT:  gt_nxt_s = sat_inc(gt_r);
        ST_BGT:  lt_nxt_s = sat_inc(lt_r);
        ST_EQ:   eq_nxt_s = sat_inc(eq_r);
        default: eq_nxt_s = eq_r;
      endcase
      if (cls_s == state_r) begin
        run_nxt_s = 4'd0;
      end else begin
        if (cls_s == cand_r) begin
          cand_new_s = cand_r;
          run_inc_s  = run_r + 4'd1;
        end else begin
          cand_new_s = cls_s;
          run_inc_s  = 4'd1;
        end
        cand_nxt_s = cand_new_s;
        if (run_inc_s == HOLD_W) begin
          // Enough agreeing samples: switch and announce the new state.
          state_nxt_s     = cand_new_s;
          run_nxt_s       = 4'd0;
          evt_valid_nxt_s = 1'b1;
          evt_state_nxt_s = cand_new_s;
        end else begin
          run_nxt_s = run_inc_s;
        end
      end
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EQ;
      cand_r      <= ST_EQ;
      run_r       <= 4'd0;
      evt_valid_r <= 1'b0;
      evt_state_r <= ST_EQ;
      gt_r        <= {CNT_W{1'b0}};
      lt_r        <= {CNT_W{1'b0}};
      eq_r        <= {CNT_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cand_r      <= cand_nxt_s;
      run_r       <= run_nxt_s;
      evt_valid_r <= evt_valid_nxt_s;
      evt_state_r <= evt_state_nxt_s;
      gt_r        <= gt_nxt_s;
      lt_r        <= lt_nxt_s;
      eq_r        <= eq_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign cur_state = state_r;
  assign evt_valid = evt_valid_r;
  assign evt_state = evt_state_r;
  assign gt_cnt    = gt_r;
  assign lt_cnt    = lt_r;
  assign eq_cnt    = eq_r;
  assign err       = err_r;

endmodule

// File: tb/tb_cmp_hyst_monitor.sv
// Directed, table-driven bench for cmp_hyst_monitor (HOLD=3, CNT_W=8),
// plus a HOLD=1 instance for the immediate-switch case and hand-written
// sequences for saturation, clear and mid-event reset.
module tb_cmp_hyst_monitor;

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, a_greater, b_greater, ab_equal, evt_ready;
  logic       in_ready, evt_valid, err;
  logic [1:0] cur_state, evt_state;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;

  logic       in_ready1, evt_valid1, err1;
  logic [1:0] cur_state1, evt_state1;
  logic [7:0] gt_cnt1, lt_cnt1, eq_cnt1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cmp_hyst_monitor #(.SIZE(4), .CNT_W(8), .HOLD(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .a_greater(a_greater), .b_greater(b_greater),
    .ab_equal(ab_equal), .cur_state(cur_state), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_state(evt_state), .gt_cnt(gt_cnt),
    .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .err(err)
  );

  cmp_hyst_monitor #(.SIZE(4), .CNT_W(8), .HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready1), .a_greater(a_greater), .b_greater(b_greater),
    .ab_equal(ab_equal), .cur_state(cur_state1), .evt_valid(evt_valid1),
    .evt_ready(evt_ready), .evt_state(evt_state1), .gt_cnt(gt_cnt1),
    .lt_cnt(lt_cnt1), .eq_cnt(eq_cnt1), .err(err1)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic [2:0] flg;   // {a_greater, b_greater, ab_equal}
    logic       er;
    logic       exp_rdy;
    logic [1:0] exp_cs;
    logic       exp_ev;
    logic [1:0] exp_es;
    logic [7:0] exp_gt;
    logic [7:0] exp_lt;
    logic [7:0] exp_eq;
    logic       exp_err;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] cs, input logic ev,
                         input logic [1:0] es, input logic [7:0] gt, input logic [7:0] lt,
                         input logic [7:0] eq, input logic er);
    chk({tag, " cur_state"}, 32'(cur_state), 32'(cs));
    chk({tag, " evt_valid"}, 32'(evt_valid), 32'(ev));
    chk({tag, " evt_state"}, 32'(evt_state), 32'(es));
    chk({tag, " gt_cnt"},    32'(gt_cnt),    32'(gt));
    chk({tag, " lt_cnt"},    32'(lt_cnt),    32'(lt));
    chk({tag, " eq_cnt"},    32'(eq_cnt),    32'(eq));
    chk({tag, " err"},       32'(err),       32'(er));
  endtask

  initial begin
    logic       ill_err;
    logic [7:0] ill_eq;
`ifdef CMP_MON_ERR_EN
    ill_err = 1'b1;
    ill_eq  = 8'd3;
`else
    ill_err = 1'b0;
    ill_eq  = 8'd4;
`endif
    //            clr   vld   flg     er    rdy   cs     ev    es     gt    lt    eq      err
    vecs[0]  = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 8'd1, 8'd0, 8'd0,   1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 8'd2, 8'd0, 8'd0,   1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 2'b01, 1'b1, 2'b01, 8'd3, 8'd0, 8'd0,   1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 8'd3, 8'd0, 8'd0,   1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 2'b01, 1'b0, 2'b01, 8'd3, 8'd1, 8'd0,   1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd3, 8'd2, 8'd0,   1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd4, 8'd2, 8'd0,   1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd4, 8'd3, 8'd0,   1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd4, 8'd4, 8'd0,   1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd4, 8'd4, 8'd1,   1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd4, 8'd4, 8'd1,   1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 8'd4, 8'd4, 8'd2,   1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 8'd4, 8'd4, 8'd3,   1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 8'd4, 8'd4, 8'd3,   1'b0};
    vecs[14] = '{1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 8'd4, 8'd4, 8'd3,   1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 8'd4, 8'd4, ill_eq, ill_err};
    vecs[16] = '{1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0,   ill_err};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; evt_ready = 1'b0;
    a_greater = 1'b0; b_greater = 1'b0; ab_equal = 1'b0;

    // Reset state.
    tick();
    tick();
    chk_all("reset", 2'b00, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      clear     = vecs[i].clr;
      in_valid  = vecs[i].vld;
      a_greater = vecs[i].flg[2];
      b_greater = vecs[i].flg[1];
      ab_equal  = vecs[i].flg[0];
      evt_ready = vecs[i].er;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].exp_cs, vecs[i].exp_ev, vecs[i].exp_es,
              vecs[i].exp_gt, vecs[i].exp_lt, vecs[i].exp_eq, vecs[i].exp_err);
      if (i == 0) begin
        chk("hold1 cur_state", 32'(cur_state1), 32'd1);
        chk("hold1 evt_valid", 32'(evt_valid1), 32'd1);
        chk("hold1 evt_state", 32'(evt_state1), 32'd1);
      end
    end

    // eq_cnt saturation.
    clear = 1'b0; in_valid = 1'b1; evt_ready = 1'b1;
    a_greater = 1'b0; b_greater = 1'b0; ab_equal = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    chk("sat eq 255", 32'(eq_cnt), 32'd255);
    for (int k = 0; k < 3; k++) tick();
    chk("sat eq hold", 32'(eq_cnt), 32'd255);
    chk("sat state", 32'(cur_state), 32'd0);

    // Move to AGT, then clear leaves state and event alone.
    a_greater = 1'b1; ab_equal = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk_all("agt", 2'b01, 1'b1, 2'b01, 8'd3, 8'd0, 8'd255, ill_err);
    clear = 1'b1; in_valid = 1'b0; evt_ready = 1'b0;
    tick();
    chk_all("clear", 2'b01, 1'b1, 2'b01, 8'd0, 8'd0, 8'd0, ill_err);
    clear = 1'b0;

    // Reset while an event is pending.
    rst_n = 1'b0;
    tick();
    chk_all("midrst", 2'b00, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
